// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion; optional stall counter under ID_EX_STALL_CNT_EN
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         IfIdRegRs,
    input  logic [4:0]         IfIdRegRt,
    input  logic [4:0]         IfIdRegRd,
    input  logic               IdValid,
    input  logic               IdRegWrite,
    input  logic               IdMemRead,
    input  logic               IdMemWrite,
    input  logic               IdMemToReg,
    input  logic               IdAluSrc,
    input  logic               IdRegDst,
    input  logic [ALUOP_W-1:0] IdAluOp,
    input  logic [DATA_W-1:0]  IdReadData1,
    input  logic [DATA_W-1:0]  IdReadData2,
    input  logic [DATA_W-1:0]  IdSignExtImm,
    input  logic               Flush,
    input  logic               Hold,
    output logic [4:0]         IdExRegRs,
    output logic [4:0]         IdExRegRt,
    output logic [4:0]         IdExRegRd,
    output logic               IdExValid,
    output logic               IdExRegWrite,
    output logic               IdExMemRead,
    output logic               IdExMemWrite,
    output logic               IdExMemToReg,
    output logic               IdExAluSrc,
    output logic               IdExRegDst,
    output logic [ALUOP_W-1:0] IdExAluOp,
    output logic [DATA_W-1:0]  IdExReadData1,
    output logic [DATA_W-1:0]  IdExReadData2,
    output logic [DATA_W-1:0]  IdExSignExtImm,
    output logic               Stall,
    output logic [15:0]        StallCount
);

    logic loadUse;
    logic loadBubble;

    // Hazard when the load in EX writes a nonzero register that ID reads
    always_comb begin
        loadUse = IdExMemRead && (IdExRegRt != 5'd0) && IdValid &&
                  ((IdExRegRt == IfIdRegRs) || (IdExRegRt == IfIdRegRt));
    end

    // Flush outranks Hold; a load-use bubble waits until Hold drops
    assign loadBubble = Flush || (!Hold && loadUse);
    assign Stall      = !Flush && (Hold || loadUse);

    // Pipeline register: reset or bubble clears everything, Hold freezes, else capture ID
    always_ff @(posedge clk) begin
        if (!rst_n || loadBubble) begin
            IdExRegRs      <= '0;
            IdExRegRt      <= '0;
            IdExRegRd      <= '0;
            IdExValid      <= 1'b0;
            IdExRegWrite   <= 1'b0;
            IdExMemRead    <= 1'b0;
            IdExMemWrite   <= 1'b0;
            IdExMemToReg   <= 1'b0;
            IdExAluSrc     <= 1'b0;
            IdExRegDst     <= 1'b0;
            IdExAluOp      <= '0;
            IdExReadData1  <= '0;
            IdExReadData2  <= '0;
            IdExSignExtImm <= '0;
        end else if (!Hold) begin
            IdExRegRs      <= IfIdRegRs;
            IdExRegRt      <= IfIdRegRt;
            IdExRegRd      <= IfIdRegRd;
            IdExValid      <= IdValid;
            IdExRegWrite   <= IdRegWrite;
            IdExMemRead    <= IdMemRead;
            IdExMemWrite   <= IdMemWrite;
            IdExMemToReg   <= IdMemToReg;
            IdExAluSrc     <= IdAluSrc;
            IdExRegDst     <= IdRegDst;
            IdExAluOp      <= IdAluOp;
            IdExReadData1  <= IdReadData1;
            IdExReadData2  <= IdReadData2;
            IdExSignExtImm <= IdSignExtImm;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stallCnt;

    // Saturating count of stalled cycles, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCnt <= 16'h0000;
        end else if (Stall && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'h0001;
        end
    end

    assign StallCount = stallCnt;
`else
    assign StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with a cycle model and directed vectors
module tb_id_ex_stage;

`ifdef ID_EX_STALL_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IfIdRegRs, IfIdRegRt, IfIdRegRd;
    logic        IdValid, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdAluSrc, IdRegDst;
    logic [3:0]  IdAluOp;
    logic [31:0] IdReadData1, IdReadData2, IdSignExtImm;
    logic        Flush, Hold;
    logic [4:0]  IdExRegRs, IdExRegRt, IdExRegRd;
    logic        IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite, IdExMemToReg, IdExAluSrc, IdExRegDst;
    logic [3:0]  IdExAluOp;
    logic [31:0] IdExReadData1, IdExReadData2, IdExSignExtImm;
    logic        Stall;
    logic [15:0] StallCount;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    id_ex_stage #(.DATA_W(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IfIdRegRd(IfIdRegRd),
        .IdValid(IdValid), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .IdMemWrite(IdMemWrite), .IdMemToReg(IdMemToReg), .IdAluSrc(IdAluSrc),
        .IdRegDst(IdRegDst), .IdAluOp(IdAluOp),
        .IdReadData1(IdReadData1), .IdReadData2(IdReadData2), .IdSignExtImm(IdSignExtImm),
        .Flush(Flush), .Hold(Hold),
        .IdExRegRs(IdExRegRs), .IdExRegRt(IdExRegRt), .IdExRegRd(IdExRegRd),
        .IdExValid(IdExValid), .IdExRegWrite(IdExRegWrite), .IdExMemRead(IdExMemRead),
        .IdExMemWrite(IdExMemWrite), .IdExMemToReg(IdExMemToReg), .IdExAluSrc(IdExAluSrc),
        .IdExRegDst(IdExRegDst), .IdExAluOp(IdExAluOp),
        .IdExReadData1(IdExReadData1), .IdExReadData2(IdExReadData2),
        .IdExSignExtImm(IdExSignExtImm),
        .Stall(Stall), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    // Model of the ID/EX contents as one record
    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic        valid, regWrite, memRead, memWrite, memToReg, aluSrc, regDst;
        logic [3:0]  aluOp;
        logic [31:0] d1, d2, imm;
    } stage_t;

    stage_t m;
    int     mCnt = 0;

    function automatic stage_t idWord();
        stage_t s;
        s.rs = IfIdRegRs; s.rt = IfIdRegRt; s.rd = IfIdRegRd;
        s.valid = IdValid; s.regWrite = IdRegWrite; s.memRead = IdMemRead;
        s.memWrite = IdMemWrite; s.memToReg = IdMemToReg; s.aluSrc = IdAluSrc;
        s.regDst = IdRegDst; s.aluOp = IdAluOp;
        s.d1 = IdReadData1; s.d2 = IdReadData2; s.imm = IdSignExtImm;
        return s;
    endfunction

    function automatic bit modelLoadUse();
        return m.memRead && (m.rt != 0) && IdValid && (m.rt == IfIdRegRs || m.rt == IfIdRegRt);
    endfunction

    function automatic bit modelStall();
        return !Flush && (Hold || modelLoadUse());
    endfunction

    // Apply the update priority: reset, flush, hold, load-use bubble, load
    always @(posedge clk) begin
        bit st;
        st = modelStall();
        if (!rst_n) begin
            m = '0;
            mCnt = 0;
        end else begin
            if (CNT_EN != 0 && st && mCnt < 65535) mCnt = mCnt + 1;
            if (Flush) m = '0;
            else if (Hold) m = m;
            else if (modelLoadUse()) m = '0;
            else m = idWord();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the rising edge
    always @(negedge clk) begin
        if (checkEn) begin
            chk("m_rs", IdExRegRs, m.rs);
            chk("m_rt", IdExRegRt, m.rt);
            chk("m_rd", IdExRegRd, m.rd);
            chk("m_ctl", {IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite, IdExMemToReg, IdExAluSrc, IdExRegDst},
                {m.valid, m.regWrite, m.memRead, m.memWrite, m.memToReg, m.aluSrc, m.regDst});
            chk("m_aluop", IdExAluOp, m.aluOp);
            chk("m_d1", IdExReadData1, m.d1);
            chk("m_d2", IdExReadData2, m.d2);
            chk("m_imm", IdExSignExtImm, m.imm);
            chk("m_stall", Stall, modelStall());
            chk("m_cnt", StallCount, mCnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic setId(input bit isLoad, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        IdValid = 1'b1;
        IfIdRegRs = rs; IfIdRegRt = rt; IfIdRegRd = rd;
        IdRegWrite = 1'b1; IdMemRead = isLoad; IdMemWrite = 1'b0;
        IdMemToReg = isLoad; IdAluSrc = isLoad; IdRegDst = !isLoad;
        IdAluOp = isLoad ? 4'h2 : 4'h6;
        IdReadData1 = 32'hA000_0000 | 32'(rs);
        IdReadData2 = 32'hB000_0000 | 32'(rt);
        IdSignExtImm = 32'h0000_1234 + 32'(rd);
    endtask

    initial begin
        rst_n = 1'b0; Flush = 1'b0; Hold = 1'b0;
        IdValid = 1'b1; IfIdRegRs = 5'h1F; IfIdRegRt = 5'h1F; IfIdRegRd = 5'h1F;
        IdRegWrite = 1'b1; IdMemRead = 1'b1; IdMemWrite = 1'b1; IdMemToReg = 1'b1;
        IdAluSrc = 1'b1; IdRegDst = 1'b1; IdAluOp = 4'hF;
        IdReadData1 = 32'hFFFF_FFFF; IdReadData2 = 32'hFFFF_FFFF; IdSignExtImm = 32'hFFFF_FFFF;
        repeat (2) step();
        checkEn = 1'b1;
        chk("rst_valid", IdExValid, 0);
        chk("rst_rt", IdExRegRt, 0);
        chk("rst_rd1", IdExReadData1, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_cnt", StallCount, 0);

        // load r2, then a consumer of r2: one bubble, then the consumer
        rst_n = 1'b1;
        setId(1'b1, 5'd1, 5'd2, 5'd0);
        step();
        chk("ld_memread", IdExMemRead, 1);
        chk("ld_rt", IdExRegRt, 2);
        setId(1'b0, 5'd2, 5'd3, 5'd4);
        #1;
        chk("lu_stall", Stall, 1);
        step();
        chk("lu_bubble_memread", IdExMemRead, 0);
        chk("lu_bubble_rs", IdExRegRs, 0);
        chk("lu_stall_clear", Stall, 0);
        step();
        chk("lu_dep_rs", IdExRegRs, 2);
        chk("lu_cnt", StallCount, CNT_EN);

        // load to $0 and independent instructions never stall
        setId(1'b1, 5'd1, 5'd0, 5'd0);
        step();
        setId(1'b0, 5'd0, 5'd0, 5'd6);
        #1;
        chk("zero_stall", Stall, 0);
        step();
        chk("zero_rd", IdExRegRd, 6);
        setId(1'b1, 5'd6, 5'd5, 5'd0);
        step();
        setId(1'b0, 5'd3, 5'd4, 5'd7);
        #1;
        chk("indep_stall", Stall, 0);
        step();
        chk("indep_rs", IdExRegRs, 3);
        chk("indep_d2", IdExReadData2, 32'hB000_0004);

        // fresh counter, then Hold for 3 cycles over a load-use hazard
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        setId(1'b1, 5'd1, 5'd7, 5'd0);
        step();
        setId(1'b0, 5'd7, 5'd2, 5'd3);
        Hold = 1'b1;
        #1;
        chk("hold_stall0", Stall, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_rt", IdExRegRt, 7);
            chk("hold_memread", IdExMemRead, 1);
            chk("hold_stall", Stall, 1);
        end
        chk("hold_cnt3", StallCount, 3 * CNT_EN);
        Hold = 1'b0;
        #1;
        chk("hold_release_stall", Stall, 1);
        step();
        chk("hold_bubble_memread", IdExMemRead, 0);
        chk("hold_cnt4", StallCount, 4 * CNT_EN);
        step();
        chk("hold_dep_rs", IdExRegRs, 7);

        // Flush beats Hold and LoadUse
        setId(1'b1, 5'd1, 5'd8, 5'd0);
        step();
        setId(1'b0, 5'd8, 5'd8, 5'd9);
        Hold = 1'b1;
        Flush = 1'b1;
        #1;
        chk("flush_stall", Stall, 0);
        step();
        chk("flush_valid", IdExValid, 0);
        chk("flush_rt", IdExRegRt, 0);
        chk("flush_d1", IdExReadData1, 0);
        chk("flush_aluop", IdExAluOp, 0);
        Flush = 1'b0;

        // long Hold drives the counter to saturation when enabled
        if (CNT_EN != 0) begin
            repeat (65540) step();
            chk("sat_cnt", StallCount, 16'hFFFF);
        end else begin
            repeat (40) step();
            chk("off_cnt", StallCount, 0);
        end
        Hold = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
